// File: rtl/data_sram_responder_pkg.sv
// Shared constants for the data SRAM responder: confreg window base and register offsets,
// plus the byte-strobe merge used by every writable word.
package data_sram_responder_pkg;

  localparam logic [31:0] CONF_BASE_DEFAULT = 32'hbfaf_0000;

  localparam logic [15:0] TIMER_OFS   = 16'h0000;
  localparam logic [15:0] LED_OFS     = 16'h0004;
  localparam logic [15:0] SWITCH_OFS  = 16'h0008;
  localparam logic [15:0] SCRATCH_OFS = 16'h000c;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  we);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_bram.sv
// Single-port, byte-write-enable, read-first synchronous RAM (registered read, no reset).
module bram_be_1r1w #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(2**ADDR_W)-1];

  // Read-first: the registered read sees the word before this cycle's byte writes land.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM port responder: word-addressed RAM plus a small confreg window
// (timer, LED, switch, scratch), fixed one-cycle read latency.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] CONF_BASE = CONF_BASE_DEFAULT,
  parameter int          IO_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            data_sram_en,
  input  logic [3:0]      data_sram_we,
  input  logic [31:0]     data_sram_addr,
  input  logic [31:0]     data_sram_wdata,
  output logic [31:0]     data_sram_rdata,
  input  logic [IO_W-1:0] switch_in,
  output logic [IO_W-1:0] led_out
);

  logic            conf_sel;
  logic [15:0]     conf_ofs;
  logic            wr_req;
  logic [31:0]     conf_rword;
  logic [31:0]     led_word;
  logic [31:0]     sw_word;
  logic [31:0]     led_merged;
  logic [31:0]     ram_rdata;
  logic            ram_en;
  logic [3:0]      ram_we;

  logic [31:0]     timer_reg;
  logic [IO_W-1:0] led_reg;
  logic [31:0]     scratch_reg;
  logic [IO_W-1:0] sw_meta_reg;
  logic [IO_W-1:0] sw_sync_reg;
  logic            resp_conf_reg;
  logic [31:0]     conf_rdata_reg;

  logic unused_addr_bits;
  assign unused_addr_bits = ^data_sram_addr[1:0];

  always_comb begin
    conf_sel   = (data_sram_addr[31:16] == CONF_BASE[31:16]);
    conf_ofs   = data_sram_addr[15:0];
    wr_req     = data_sram_en && (data_sram_we != 4'b0000);
    led_word   = '0;
    led_word[IO_W-1:0] = led_reg;
    sw_word    = '0;
    sw_word[IO_W-1:0]  = sw_sync_reg;
    led_merged = merge_bytes(led_word, data_sram_wdata, data_sram_we);
    unique case (conf_ofs)
      TIMER_OFS:   conf_rword = timer_reg;
      LED_OFS:     conf_rword = led_word;
      SWITCH_OFS:  conf_rword = sw_word;
      SCRATCH_OFS: conf_rword = scratch_reg;
      default:     conf_rword = '0;
    endcase
  end

  // RAM is blocked entirely while in reset so a concurrent write cannot land.
  always_comb begin
    ram_en = data_sram_en && !conf_sel && !reset;
    ram_we = ram_en ? data_sram_we : 4'b0000;
  end

  bram_be_1r1w #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (data_sram_addr[ADDR_W+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg      <= '0;
      led_reg        <= '0;
      scratch_reg    <= '0;
      sw_meta_reg    <= '0;
      sw_sync_reg    <= '0;
      resp_conf_reg  <= 1'b1;
      conf_rdata_reg <= '0;
    end else begin
      sw_meta_reg <= switch_in;
      sw_sync_reg <= sw_meta_reg;
      if (wr_req && conf_sel && conf_ofs == TIMER_OFS)
        timer_reg <= merge_bytes(timer_reg, data_sram_wdata, data_sram_we);
      else
        timer_reg <= timer_reg + 32'd1;
      if (data_sram_en) begin
        resp_conf_reg  <= conf_sel;
        conf_rdata_reg <= conf_rword;
      end
      if (wr_req && conf_sel && conf_ofs == LED_OFS)
        led_reg <= led_merged[IO_W-1:0];
      if (wr_req && conf_sel && conf_ofs == SCRATCH_OFS)
        scratch_reg <= merge_bytes(scratch_reg, data_sram_wdata, data_sram_we);
    end
  end

  // Reset points the response mux at the cleared confreg register, so rdata reads 0.
  assign data_sram_rdata = resp_conf_reg ? conf_rdata_reg : ram_rdata;
  assign led_out         = led_reg;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: read expectations go to a scoreboard queue, a monitor pops them
// one cycle after each read request.
module tb_data_sram_responder;
  import data_sram_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] switch_in;
  logic [15:0] led_out;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] last_exp;

  always #5 clk = ~clk;

  data_sram_responder #(
    .ADDR_W(12), .CONF_BASE(32'hbfaf_0000), .IO_W(16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_in       (switch_in),
    .led_out         (led_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s got=%08h", tag, got);
    end
  endtask

  // Monitor: every accepted read yields one response one cycle later.
  always @(posedge clk) begin
    if (!reset && data_sram_en && data_sram_we == 4'b0000) begin
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string t = tag_q.pop_front();
        check(t, data_sram_rdata, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    data_sram_en    = 1'b1;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = data;
    step();
    data_sram_en = 1'b0;
    data_sram_we = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    last_exp        = exp;
    data_sram_en    = 1'b1;
    data_sram_we    = 4'b0000;
    data_sram_addr  = addr;
    data_sram_wdata = 32'h0;
    step();
    data_sram_en = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'b0000;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    switch_in       = 16'h0000;
    step();
    step();
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led_out}, 32'h0);
    reset = 1'b0;

    // Timer starts at 0 the cycle after reset; a read issued then returns 0.
    rd(32'hbfaf_0000 | TIMER_OFS, 32'h0, "timer_after_reset");

    wr(32'h1c00_0100, 32'h1234_5678, 4'hF);
    rd(32'h1c00_0100, 32'h1234_5678, "ram_wr_rd");

    // en=0 keeps the last response on rdata.
    step();
    step();
    check("rdata_hold", data_sram_rdata, last_exp);

    wr(32'h1c00_0104, 32'hAABB_CCDD, 4'hF);
    wr(32'h1c00_0104, 32'h1122_3344, 4'b0101);
    rd(32'h1c00_0104, 32'hAA22_CC44, "ram_byte_strobe");

    wr(32'h1c00_0000, 32'hCAFE_F00D, 4'hF);
    rd(32'h1c00_4000, 32'hCAFE_F00D, "ram_alias");

    // A few scattered words, read back in reverse order.
    for (int i = 0; i < 4; i++)
      wr(32'h1c00_0200 + 32'(i * 4), 32'h0101_0101 * 32'(i + 1), 4'hF);
    for (int i = 3; i >= 0; i--)
      rd(32'h1c00_0200 + 32'(i * 4), 32'h0101_0101 * 32'(i + 1), $sformatf("ram_word%0d", i));

    // Read-first on a write cycle: the response carries the old word.
    wr(32'h1c00_0200, 32'h5555_5555, 4'hF);
    check("ram_read_first", data_sram_rdata, 32'h0101_0101);

    wr(32'hbfaf_0000, 32'hFFFF_FFFE, 4'hF);
    rd(32'hbfaf_0000, 32'hFFFF_FFFE, "timer_0");
    rd(32'hbfaf_0000, 32'hFFFF_FFFF, "timer_1");
    rd(32'hbfaf_0000, 32'h0000_0000, "timer_wrap");

    wr(32'hbfaf_0004, 32'h0001_A5A5, 4'hF);
    check("led_out", {16'h0, led_out}, 32'h0000_A5A5);
    rd(32'hbfaf_0004, 32'h0000_A5A5, "led_read");
    wr(32'hbfaf_0004, 32'h0000_3C00, 4'b0010);
    check("led_byte", {16'h0, led_out}, 32'h0000_3CA5);

    switch_in = 16'h00F0;
    step();
    step();
    step();
    rd(32'hbfaf_0008, 32'h0000_00F0, "switch_read");
    wr(32'hbfaf_0008, 32'hFFFF_FFFF, 4'hF);
    rd(32'hbfaf_0008, 32'h0000_00F0, "switch_ro");

    wr(32'hbfaf_000c, 32'h8765_4321, 4'hF);
    wr(32'hbfaf_000c, 32'h0000_00EE, 4'b0001);
    rd(32'hbfaf_000c, 32'h8765_43EE, "scratch_rw");
    wr(32'hbfaf_0010, 32'h1111_1111, 4'hF);
    rd(32'hbfaf_0010, 32'h0, "unmapped");

    // Reset with a concurrent SCRATCH write: the write is dropped.
    reset = 1'b1;
    wr(32'hbfaf_000c, 32'hDEAD_BEEF, 4'hF);
    reset = 1'b0;
    check("reset_mid_rdata", data_sram_rdata, 32'h0);
    check("reset_mid_led", {16'h0, led_out}, 32'h0);
    rd(32'hbfaf_000c, 32'h0, "scratch_after_reset");

    // RAM write presented during reset must also be suppressed.
    reset = 1'b1;
    wr(32'h1c00_0100, 32'hDEAD_BEEF, 4'hF);
    reset = 1'b0;
    rd(32'h1c00_0100, 32'h1234_5678, "ram_reset_write_blocked");

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
